// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// It serves MEM-stage loads and stores and refills from or writes back to a 256-bit block memory.
module dcache_ctrl #(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        p1_addr_i,
  input  logic [31:0]        p1_data_i,
  input  logic               p1_MemRead_i,
  input  logic               p1_MemWrite_i,
  output logic [31:0]        p1_data_o,
  output logic               p1_stall_o,
  output logic [31:0]        mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(BLOCK_W / 8);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, WAIT_HIT} state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;
  logic               mem_enable_q;
  logic               mem_write_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;
  logic              req;
  logic              hit;
  logic              idle;
  logic              hit_wr;
  logic              unused_addr_bits;

  assign req_tag          = p1_addr_i[31 -: TAG_W];
  assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
  assign req_word         = p1_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req    = p1_MemRead_i | p1_MemWrite_i;
  assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle   = (state_q == IDLE);
  assign hit_wr = idle && p1_MemWrite_i && hit;

  // Gated by rst_i so an aborted miss releases the pipeline even while the request is still held.
  assign p1_stall_o = rst_i && (!idle || (req && !hit));
  assign p1_data_o  = (rst_i && idle && p1_MemRead_i && !p1_MemWrite_i && hit)
                      ? data_q[req_idx][{req_word, 5'b0} +: 32] : 32'h0;

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_data_o   = (state_q == WRITEBACK) ? data_q[miss_idx_q] : '0;

  always_comb begin
    mem_addr_o = 32'h0;
    case (state_q)
      WRITEBACK: mem_addr_o = {tag_q[miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
      ALLOCATE:  mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
      default:   mem_addr_o = 32'h0;
    endcase
  end

  // Memory handshake outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p1_MemWrite_i && hit) begin
            dirty_q[req_idx] <= 1'b1;
          end else if (req && !hit) begin
            miss_tag_q   <= req_tag;
            miss_idx_q   <= req_idx;
            mem_enable_q <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
            end else begin
              state_q     <= ALLOCATE;
              mem_write_q <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_q     <= ALLOCATE;
            mem_write_q <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_q             <= WAIT_HIT;
            mem_enable_q        <= 1'b0;
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
          end
        end
        WAIT_HIT: state_q <= IDLE;
        default: begin
          state_q      <= IDLE;
          mem_enable_q <= 1'b0;
          mem_write_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (hit_wr) begin
      data_q[req_idx][{req_word, 5'b0} +: 32] <= p1_data_i;
    end
    if ((state_q == ALLOCATE) && mem_ack_i) begin
      data_q[miss_idx_q] <= mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a flat-memory golden model
// and a behavioural block memory that answers the cache's requests.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i;
  logic         respAck = 1'b0;
  logic         strayAck = 1'b0;

  assign mem_ack_i = respAck | strayAck;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
    int           delay;
  } memReq_t;

  memReq_t     reqLog[$];
  memReq_t     curReq;
  logic [31:0] memImg [logic [31:0]];
  logic [31:0] refW   [logic [31:0]];
  int          fixedDelay = 0;
  int          respCnt = 0;
  bit          respBusy = 0;
  int          passCount = 0;
  int          checkCount = 0;

  bit          mValid [32];
  bit          mDirty [32];
  logic [21:0] mTag   [32];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return memImg.exists(k) ? memImg[k] : initWord(k);
  endfunction

  function automatic logic [31:0] goldWord(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return refW.exists(k) ? refW[k] : initWord(k);
  endfunction

  function automatic logic [255:0] memBlock(input logic [31:0] b);
    logic [255:0] blk;
    for (int w = 0; w < 8; w++) blk[w*32 +: 32] = memWord(b + 32'(w * 4));
    return blk;
  endfunction

  function automatic logic [255:0] goldBlock(input logic [31:0] b);
    logic [255:0] blk;
    for (int w = 0; w < 8; w++) blk[w*32 +: 32] = goldWord(b + 32'(w * 4));
    return blk;
  endfunction

  // Behavioural block memory: accepts one request at a time and acks after curReq.delay cycles.
  initial begin
    forever begin
      @(negedge clk_i);
      respAck = 1'b0;
      if (!rst_i) begin
        respBusy = 0;
      end else if (!respBusy) begin
        if (mem_enable_o) begin
          curReq.addr  = mem_addr_o;
          curReq.wr    = mem_write_o;
          curReq.data  = mem_data_o;
          curReq.delay = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 6));
          respCnt      = curReq.delay;
          respBusy     = 1;
          reqLog.push_back(curReq);
        end
      end else begin
        respCnt--;
        if (respCnt == 0) begin
          respBusy = 0;
          respAck  = 1'b1;
          if (curReq.wr) begin
            for (int w = 0; w < 8; w++) memImg[curReq.addr + 32'(w * 4)] = curReq.data[w*32 +: 32];
          end else begin
            mem_data_i = memBlock(curReq.addr);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [4:0]   idx;
    logic [21:0]  tg;
    bit           expHit;
    bit           expWb;
    logic [31:0]  wbAddr;
    logic [255:0] wbData;
    int           expN;
    int           stallCycles;
    int           sumDelay;
    idx    = a[9:5];
    tg     = a[31:10];
    expHit = mValid[idx] && (mTag[idx] == tg);
    expWb  = !expHit && mValid[idx] && mDirty[idx];
    wbAddr = {mTag[idx], idx, 5'b0};
    wbData = goldBlock(wbAddr);
    reqLog.delete();
    @(negedge clk_i);
    p1_addr_i     = a;
    p1_data_i     = d;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    #1;
    checkOutput("stall_at_request", p1_stall_o, !expHit);
    if (!expHit) begin
      checkOutput("data_zero_during_miss", p1_data_o, 32'h0);
      stallCycles = 1;
      while (p1_stall_o === 1'b1 && stallCycles < 500) begin
        @(negedge clk_i);
        #1;
        if (p1_stall_o === 1'b1) stallCycles++;
      end
      checkOutput("miss_completes", p1_stall_o, 1'b0);
      expN = expWb ? 2 : 1;
      checkOutput("mem_req_count", reqLog.size(), expN);
      if (reqLog.size() == expN) begin
        if (expWb) begin
          checkOutput("wb_addr", reqLog[0].addr, wbAddr);
          checkOutput("wb_write", reqLog[0].wr, 1'b1);
          checkOutput("wb_data", reqLog[0].data, wbData);
        end
        checkOutput("alloc_addr", reqLog[expN-1].addr, {a[31:5], 5'b0});
        checkOutput("alloc_write", reqLog[expN-1].wr, 1'b0);
        sumDelay = 0;
        foreach (reqLog[i]) sumDelay += reqLog[i].delay;
        checkOutput("stall_cycles", stallCycles, sumDelay + 2 + expN);
      end
    end else begin
      checkOutput("no_mem_on_hit", mem_enable_o, 1'b0);
    end
    checkOutput("load_data", p1_data_o, (rd && !wr) ? goldWord(a) : 32'h0);
    if (wr) begin
      refW[{a[31:2], 2'b00}] = d;
      mDirty[idx] = 1;
    end else if (!expHit) begin
      mDirty[idx] = 0;
    end
    mValid[idx] = 1;
    mTag[idx]   = tg;
  endtask

  task automatic idleCycles(input int n, input bit strays);
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      strayAck = strays && (i % 4 == 1);
      #1;
      checkOutput("idle_enable", mem_enable_o, 1'b0);
      checkOutput("idle_stall", p1_stall_o, 1'b0);
      checkOutput("idle_data", p1_data_o, 32'h0);
    end
    @(negedge clk_i);
    strayAck = 1'b0;
  endtask

  initial begin
    logic [31:0] w2;
    logic [21:0] rt;
    logic [4:0]  ri;
    logic [2:0]  rw;
    bit          rwr;
    rst_i         = 1'b0;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
      mTag[i]   = '0;
    end
    memImg[32'h0000_0404] = 32'hDEAD_BEEF;
    refW[32'h0000_0404]   = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("reset_enable", mem_enable_o, 1'b0);
    checkOutput("reset_write", mem_write_o, 1'b0);
    checkOutput("reset_stall", p1_stall_o, 1'b0);
    checkOutput("reset_data", p1_data_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    fixedDelay = 10;
    applyStimulus(1, 0, 32'h0000_0404, 32'h0);
    checkOutput("cold_read_word", p1_data_o, 32'hDEAD_BEEF);
    fixedDelay = 0;

    applyStimulus(0, 1, 32'h0000_0408, 32'h1234_5678);
    applyStimulus(1, 0, 32'h0000_0408, 32'h0);
    checkOutput("write_hit_readback", p1_data_o, 32'h1234_5678);

    applyStimulus(1, 0, 32'h0000_0804, 32'h0);
    w2 = (reqLog.size() > 0) ? reqLog[0].data[95:64] : 32'hxxxx_xxxx;
    checkOutput("evict_word2", w2, 32'h1234_5678);

    applyStimulus(1, 0, 32'h0000_0C04, 32'h0);

    idleCycles(20, 1);
    applyStimulus(1, 0, 32'h0000_0C04, 32'h0);

    applyStimulus(1, 1, 32'h0000_0C08, 32'hCAFE_0001);
    applyStimulus(1, 0, 32'h0000_0C08, 32'h0);

    for (int n = 0; n < 150; n++) begin
      rt  = 22'($urandom_range(1, 4));
      ri  = 5'($urandom_range(0, 3));
      rw  = 3'($urandom_range(0, 7));
      rwr = 1'($urandom_range(0, 1));
      applyStimulus(!rwr, rwr, {rt, ri, rw, 2'b00}, $urandom);
    end

    // Abort a refill with reset partway through ALLOCATE.
    fixedDelay = 20;
    reqLog.delete();
    @(negedge clk_i);
    p1_addr_i     = 32'h0001_00A4;
    p1_MemRead_i  = 1'b1;
    p1_MemWrite_i = 1'b0;
    #1;
    checkOutput("abort_stall_at_request", p1_stall_o, 1'b1);
    repeat (4) @(negedge clk_i);
    #1;
    checkOutput("abort_alloc_enable", mem_enable_o, 1'b1);
    checkOutput("abort_alloc_write", mem_write_o, 1'b0);
    checkOutput("abort_alloc_addr", mem_addr_o, 32'h0001_00A0);
    rst_i = 1'b0;
    #1;
    checkOutput("abort_enable_drop", mem_enable_o, 1'b0);
    checkOutput("abort_stall_drop", p1_stall_o, 1'b0);
    checkOutput("abort_data", p1_data_o, 32'h0);
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
    end
    refW = memImg;
    fixedDelay = 0;

    applyStimulus(1, 0, 32'h0001_00A4, 32'h0);
    applyStimulus(1, 0, 32'h0000_0C08, 32'h0);
    applyStimulus(1, 0, 32'h0000_0404, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
